// File: rtl/arm_mem_defs.sv
// Shared definitions for the I/D memory port arbiter.
//   - FSM state encodings used by the arbiter and visible on its debug port
//   - default address/data widths and default D-streak limit
//   - helper for sizing the streak counter
package arm_mem_defs;

    localparam int ARM_ADDR_W       = 32;
    localparam int ARM_DATA_W       = 32;
    localparam int ARM_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Bits needed to count 0..max inclusive (at least one bit).
    function automatic int streak_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive D grants made while I was waiting.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   inc_i          count one more D grant (saturates at MAX)
//   clr_i          clear the count (wins over inc_i)
//   limit_hit_o    count has reached MAX; I must win the next tie
module arb_streak_counter
    import arm_mem_defs::*;
#(
    parameter int MAX = ARM_MAX_D_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_hit_o
);

    localparam int CW = streak_w(MAX);
    localparam logic [CW-1:0] LIMIT = CW'(MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and memory-stage (D) ports onto one single-port
// memory. One transaction at a time; read data and ready pulses are registered.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ready    fetch port
//   d_req/d_we/d_addr/d_wdata
//                -> d_rdata/d_ready    data port
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (latched at grant)
//   mem_rdata/mem_valid                memory response (zero-wait allowed)
//   dbg_state_o                        current FSM state
//
// Handshake: a requester holds req (and its payload) high until its ready
// pulses; ready is a single-cycle pulse in the cycle after mem_valid. The
// memory sees mem_req as a level from the cycle after the grant until the
// cycle in which it answers with mem_valid.
module mem_port_arbiter
    import arm_mem_defs::*;
#(
    parameter int ADDR_W       = ARM_ADDR_W,
    parameter int DATA_W       = ARM_DATA_W,
    parameter int MAX_D_STREAK = ARM_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output arb_state_e        dbg_state_o
);

    arb_state_e state_q;

    logic is_idle;
    logic i_elig;
    logic d_elig;
    logic d_grant;
    logic i_grant;
    logic streak_inc;
    logic streak_clr;
    logic limit_hit;

    // A port whose ready is pulsing still shows its old request this cycle;
    // masking it keeps the completed request from being granted twice.
    always_comb begin
        is_idle    = (state_q == ST_IDLE);
        i_elig     = i_req && !i_ready;
        d_elig     = d_req && !d_ready;
        d_grant    = is_idle && d_elig && (!i_elig || !limit_hit);
        i_grant    = is_idle && i_elig && !d_grant;
        streak_inc = d_grant && i_elig;
        streak_clr = i_grant || (is_idle && !i_elig);
    end

    arb_streak_counter #(
        .MAX (MAX_D_STREAK)
    ) u_streak (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (streak_inc),
        .clr_i       (streak_clr),
        .limit_hit_o (limit_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (d_grant) begin
                        state_q   <= ST_BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (i_grant) begin
                        state_q  <= ST_BUSY_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_valid) begin
                        state_q <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        i_ready <= 1'b1;
                        i_rdata <= mem_rdata;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_valid) begin
                        state_q <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        // Stores leave the last load value in place.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state_o = state_q;

endmodule
